// File: rtl/dose_sched_pkg.sv
// Shared types and constants for the pill dose scheduler.
// DOSE_SNOOZE_EN enables the SNOOZE state and its timer in dose_channel.
package dose_sched_pkg;

    localparam int MISS_W         = 4;
    localparam int SNOOZE_DEFAULT = 10;

    typedef enum logic [1:0] {
        CH_OFF    = 2'd0,
        CH_COUNT  = 2'd1,
        CH_DUE    = 2'd2,
        CH_SNOOZE = 2'd3
    } ch_state_e;

endpackage

// File: rtl/dose_channel.sv
// One pill channel: interval/remaining counters, missed counter and state.
// DOSE_SNOOZE_EN adds the SNOOZE state with a SNOOZE_MIN tick timer.
module dose_channel
    import dose_sched_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int SNOOZE_MIN = SNOOZE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              cfg_we,
    input  logic [CNT_W-1:0]  cfg_interval,
    input  logic              ack,
    input  logic              snooze,
    output logic              is_due,
    output logic              is_count,
    output logic [CNT_W-1:0]  remaining,
    output logic [MISS_W-1:0] missed
);

    ch_state_e          state_q, state_d;
    logic [CNT_W-1:0]   interval_q, interval_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [MISS_W-1:0]  missed_q, missed_d;
    logic               rem_last;

`ifdef DOSE_SNOOZE_EN
    logic [CNT_W-1:0]   snz_q, snz_d;
`else
    logic               unused_snooze;
    assign unused_snooze = snooze;
`endif

    assign rem_last = (remaining_q == CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        interval_d  = interval_q;
        remaining_d = remaining_q;
        missed_d    = missed_q;
`ifdef DOSE_SNOOZE_EN
        snz_d       = snz_q;
`endif
        if (cfg_we) begin
            interval_d  = cfg_interval;
            remaining_d = cfg_interval;
            missed_d    = '0;
            state_d     = (cfg_interval != '0) ? CH_COUNT : CH_OFF;
        end else begin
            case (state_q)
                CH_COUNT: begin
                    if (tick) begin
                        if (rem_last) begin
                            state_d     = CH_DUE;
                            remaining_d = interval_q;
                        end else begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end
                    end
                end
                CH_DUE: begin
                    if (ack) begin
                        state_d     = CH_COUNT;
                        remaining_d = interval_q;
`ifdef DOSE_SNOOZE_EN
                    end else if (snooze) begin
                        state_d = CH_SNOOZE;
                        snz_d   = CNT_W'(SNOOZE_MIN);
`endif
                    end else if (tick) begin
                        // an unacknowledged interval elapsing counts as a miss
                        if (rem_last) begin
                            remaining_d = interval_q;
                            if (missed_q != '1)
                                missed_d = missed_q + MISS_W'(1);
                        end else begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end
                    end
                end
`ifdef DOSE_SNOOZE_EN
                CH_SNOOZE: begin
                    if (tick) begin
                        if (snz_q <= CNT_W'(1))
                            state_d = CH_DUE;
                        else
                            snz_d = snz_q - CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CH_OFF;
            interval_q  <= '0;
            remaining_q <= '0;
            missed_q    <= '0;
`ifdef DOSE_SNOOZE_EN
            snz_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            interval_q  <= interval_d;
            remaining_q <= remaining_d;
            missed_q    <= missed_d;
`ifdef DOSE_SNOOZE_EN
            snz_q       <= snz_d;
`endif
        end
    end

    assign is_due    = (state_q == CH_DUE);
    assign is_count  = (state_q == CH_COUNT);
    assign remaining = remaining_q;
    assign missed    = missed_q;

endmodule

// File: rtl/dose_scheduler.sv
// Multi-channel pill dose scheduler: alarm priority and next-dose selection.
// Define DOSE_SNOOZE_EN to enable patient snooze of the presented alarm.
module dose_scheduler
    import dose_sched_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int CNT_W      = 12,
    parameter int SNOOZE_MIN = SNOOZE_DEFAULT,
    localparam int ID_W      = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              cfg_we,
    input  logic [ID_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_interval,
    input  logic              ack,
    input  logic              snooze,
    output logic              alarm_valid,
    output logic [ID_W-1:0]   alarm_ch,
    output logic [MISS_W-1:0] alarm_missed,
    output logic [ID_W-1:0]   next_ch,
    output logic [CNT_W-1:0]  next_remaining,
    output logic [NUM_CH-1:0] pending
);

    logic [NUM_CH-1:0] due_w, count_w;
    logic [CNT_W-1:0]  rem_w  [NUM_CH];
    logic [MISS_W-1:0] miss_w [NUM_CH];

    logic              alarm_valid_q, alarm_valid_d;
    logic [ID_W-1:0]   alarm_ch_q, alarm_ch_d;
    logic [MISS_W-1:0] alarm_missed_q, alarm_missed_d;
    logic [ID_W-1:0]   next_ch_q, next_ch_d;
    logic [CNT_W-1:0]  next_rem_q, next_rem_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic              next_found;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = alarm_valid_q && (alarm_ch_q == ID_W'(i));

        dose_channel #(
            .CNT_W      (CNT_W),
            .SNOOZE_MIN (SNOOZE_MIN)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .tick         (tick),
            .cfg_we       (cfg_we && (cfg_ch == ID_W'(i))),
            .cfg_interval (cfg_interval),
            .ack          (ack && hit),
            .snooze       (snooze && hit),
            .is_due       (due_w[i]),
            .is_count     (count_w[i]),
            .remaining    (rem_w[i]),
            .missed       (miss_w[i])
        );
    end

    always_comb begin
        alarm_valid_d  = 1'b0;
        alarm_ch_d     = '0;
        alarm_missed_d = '0;
        pending_d      = due_w;
        // walk downward so the lowest DUE index wins
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (due_w[i]) begin
                alarm_valid_d  = 1'b1;
                alarm_ch_d     = ID_W'(i);
                alarm_missed_d = miss_w[i];
            end
        end
    end

    always_comb begin
        next_found = 1'b0;
        next_ch_d  = '0;
        next_rem_d = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (count_w[i] && (!next_found || rem_w[i] < next_rem_d)) begin
                next_found = 1'b1;
                next_ch_d  = ID_W'(i);
                next_rem_d = rem_w[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_valid_q  <= 1'b0;
            alarm_ch_q     <= '0;
            alarm_missed_q <= '0;
            pending_q      <= '0;
            next_ch_q      <= '0;
            next_rem_q     <= '1;
        end else begin
            alarm_valid_q  <= alarm_valid_d;
            alarm_ch_q     <= alarm_ch_d;
            alarm_missed_q <= alarm_missed_d;
            pending_q      <= pending_d;
            next_ch_q      <= next_ch_d;
            next_rem_q     <= next_rem_d;
        end
    end

    assign alarm_valid    = alarm_valid_q;
    assign alarm_ch       = alarm_ch_q;
    assign alarm_missed   = alarm_missed_q;
    assign pending        = pending_q;
    assign next_ch        = next_ch_q;
    assign next_remaining = next_rem_q;

endmodule

// File: tb/tb_dose_scheduler.sv
// Scoreboard bench for dose_scheduler: directed stimulus, queued expectations.
// Snooze expectations follow DOSE_SNOOZE_EN.
module tb_dose_scheduler;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 12;
    localparam int ID_W   = 3;
    localparam int NONE   = 4095;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tick = 1'b0;
    logic              cfg_we = 1'b0;
    logic [ID_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_interval = '0;
    logic              ack = 1'b0;
    logic              snooze = 1'b0;
    logic              alarm_valid;
    logic [ID_W-1:0]   alarm_ch;
    logic [3:0]        alarm_missed;
    logic [ID_W-1:0]   next_ch;
    logic [CNT_W-1:0]  next_remaining;
    logic [NUM_CH-1:0] pending;

    dose_scheduler #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .SNOOZE_MIN (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .cfg_we         (cfg_we),
        .cfg_ch         (cfg_ch),
        .cfg_interval   (cfg_interval),
        .ack            (ack),
        .snooze         (snooze),
        .alarm_valid    (alarm_valid),
        .alarm_ch       (alarm_ch),
        .alarm_missed   (alarm_missed),
        .next_ch        (next_ch),
        .next_remaining (next_remaining),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        string name;
        int    fld;
        int    val;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    function automatic int actual(int f);
        case (f)
            0:       return int'(alarm_valid);
            1:       return int'(alarm_ch);
            2:       return int'(alarm_missed);
            3:       return int'(pending);
            4:       return int'(next_ch);
            default: return int'(next_remaining);
        endcase
    endfunction

    function automatic string fname(int f);
        case (f)
            0:       return "alarm_valid";
            1:       return "alarm_ch";
            2:       return "alarm_missed";
            3:       return "pending";
            4:       return "next_ch";
            default: return "next_remaining";
        endcase
    endfunction

    // monitor: outputs are stable at the falling edge
    always @(negedge clk) begin
        exp_t e;
        int   a;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            a = actual(e.fld);
            checks++;
            if (e.cyc != cyc || a != e.val) begin
                errors++;
                $display("FAIL %s.%s: got %0d expected %0d (cycle %0d, due %0d)",
                         e.name, fname(e.fld), a, e.val, cyc, e.cyc);
            end
        end
    end

    task automatic push(string name, int fld, int val);
        exp_t e;
        e.cyc  = cyc + 1;
        e.name = name;
        e.fld  = fld;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic exp_alarm(string name, int v, int ch, int m);
        push(name, 0, v);
        push(name, 1, ch);
        push(name, 2, m);
    endtask

    task automatic exp_pend(string name, int p);
        push(name, 3, p);
    endtask

    task automatic exp_next(string name, int ch, int rem);
        push(name, 4, ch);
        push(name, 5, rem);
    endtask

    task automatic apply(bit t, bit w, int ch, int iv, bit a, bit s);
        tick         = t;
        cfg_we       = w;
        cfg_ch       = ID_W'(ch);
        cfg_interval = CNT_W'(iv);
        ack          = a;
        snooze       = s;
        @(negedge clk);
        tick   = 1'b0;
        cfg_we = 1'b0;
        ack    = 1'b0;
        snooze = 1'b0;
    endtask

    task automatic cfg(int ch, int iv);
        apply(1'b0, 1'b1, ch, iv, 1'b0, 1'b0);
    endtask

    task automatic do_tick(int n);
        repeat (n) apply(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_ack();
        apply(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        exp_alarm("rst", 0, 0, 0);
        exp_pend("rst", 0);
        exp_next("rst", 0, NONE);
        @(negedge clk);
        reset = 1'b0;

        // first dose comes due after three ticks
        cfg(2, 3);
        do_tick(2);
        exp_alarm("t1_pre", 0, 0, 0);
        exp_next("t1_pre", 2, 1);
        do_tick(1);
        exp_pend("t1_due", 'h04);
        exp_alarm("t1_due", 1, 2, 0);
        exp_next("t1_due", 0, NONE);
        @(negedge clk);
        apply(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
`ifdef DOSE_SNOOZE_EN
        exp_pend("snz", 'h00);
        do_tick(9);
        exp_pend("snz9", 'h00);
        do_tick(1);
        exp_pend("snz10", 'h04);
`else
        exp_pend("snz_ign", 'h04);
        do_tick(10);
        exp_alarm("snz_ign", 1, 2, 3);
`endif
        cfg(2, 0);
        exp_pend("t1_off", 'h00);
        exp_alarm("t1_off", 0, 0, 0);

        // two simultaneous alarms, acked in priority order
        cfg(1, 1);
        cfg(5, 1);
        do_tick(1);
        exp_pend("t2_both", 'h22);
        exp_alarm("t2_both", 1, 1, 0);
        @(negedge clk);
        do_ack();
        exp_pend("t2_ack1", 'h20);
        exp_alarm("t2_ack1", 1, 5, 0);
        exp_next("t2_ack1", 1, 1);
        @(negedge clk);
        do_ack();
        exp_alarm("t2_ack2", 0, 0, 0);
        exp_next("t2_tie", 1, 1);
        cfg(1, 0);
        cfg(5, 0);

        // missed doses; ack before the alarm is visible is ignored
        cfg(0, 2);
        do_tick(2);
        do_ack();
        exp_alarm("t3_ign", 1, 0, 0);
        do_tick(4);
        exp_alarm("t3_miss", 1, 0, 2);
        cfg(0, 2);
        exp_alarm("t3_recfg", 0, 0, 0);
        do_tick(2);
        exp_alarm("t3_clr", 1, 0, 0);
        cfg(0, 0);

        // next-dose selection
        cfg(3, 5);
        cfg(6, 5);
        exp_next("t4_load", 3, 5);
        do_tick(2);
        exp_next("t4_tick", 3, 3);
        cfg(7, 2);
        exp_next("t4_ch7", 7, 2);
        cfg(7, 0);
        exp_next("t4_off7", 3, 3);
        cfg(3, 0);
        exp_next("t4_off3", 6, 3);
        cfg(6, 0);
        exp_next("t4_none", 0, NONE);

        // configuration wins over tick and ack on the same channel
        cfg(4, 1);
        do_tick(1);
        @(negedge clk);
        do_tick(1);
        exp_alarm("t5_miss", 1, 4, 1);
        apply(1'b1, 1'b1, 4, 7, 1'b1, 1'b0);
        exp_alarm("t5_cfg", 0, 0, 0);
        exp_pend("t5_cfg", 'h00);
        exp_next("t5_cfg", 4, 7);
        apply(1'b1, 1'b1, 4, 1, 1'b0, 1'b0);
        exp_next("t5_cfg1", 4, 1);
        do_tick(1);
        exp_alarm("t5_due", 1, 4, 0);

        // reset during an alarm and a countdown
        cfg(1, 3);
        exp_next("t6_pre", 1, 3);
        @(negedge clk);
        reset = 1'b1;
        exp_alarm("t6_rst", 0, 0, 0);
        exp_pend("t6_rst", 'h00);
        exp_next("t6_rst", 0, NONE);
        @(negedge clk);
        reset = 1'b0;
        do_tick(5);
        exp_alarm("t6_post", 0, 0, 0);
        exp_pend("t6_post", 'h00);
        exp_next("t6_post", 0, NONE);

        repeat (3) @(negedge clk);
        checks++;
        if (alarm_valid !== 1'b0) begin
            errors++;
            $display("FAIL end.alarm_valid: got %0d", alarm_valid);
        end
        checks++;
        if (pending !== '0) begin
            errors++;
            $display("FAIL end.pending: got %0h", pending);
        end
        checks++;
        if (next_ch !== '0) begin
            errors++;
            $display("FAIL end.next_ch: got %0d", next_ch);
        end
        checks++;
        if (next_remaining !== CNT_W'(NONE)) begin
            errors++;
            $display("FAIL end.next_remaining: got %0d", next_remaining);
        end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s.%s: never checked, expected %0d",
                     e.name, fname(e.fld), e.val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
